// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU with tag pass-through.
// Optional macro DIV_EARLY_OUT_EN skips leading-zero iterations of the dividend.
`timescale 1ns/1ps
module div_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [TAG_W-1:0] tag,
  input  logic [XLEN-1:0]  dividend,
  input  logic [XLEN-1:0]  divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

  state_t           state_reg;
  logic [1:0]       op_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [XLEN-1:0]  dividend_reg;
  logic [XLEN-1:0]  divisor_reg;
  logic [XLEN-1:0]  dvs_reg;
  logic [XLEN:0]    rem_reg;
  logic [XLEN-1:0]  q_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             neg_q_reg;
  logic             neg_r_reg;
  logic             dbz_reg;
  logic             ovf_reg;

  logic             is_signed;
  logic             dvd_neg;
  logic             dvs_neg;
  logic [XLEN-1:0]  abs_dvd;
  logic [XLEN-1:0]  abs_dvs;
  logic             dbz;
  logic             ovf;
  logic [XLEN-1:0]  q_init;
  logic [CNT_W-1:0] cnt_init;
  logic [XLEN:0]    shifted;
  logic [XLEN:0]    trial;
  logic             ge;
  logic [XLEN-1:0]  q_fix;
  logic [XLEN-1:0]  r_fix;

  assign in_ready  = (state_reg == IDLE);

  assign is_signed = ~op_reg[0];
  assign dvd_neg   = is_signed & dividend_reg[XLEN-1];
  assign dvs_neg   = is_signed & divisor_reg[XLEN-1];
  assign abs_dvd   = dvd_neg ? (~dividend_reg + 1'b1) : dividend_reg;
  assign abs_dvs   = dvs_neg ? (~divisor_reg + 1'b1) : divisor_reg;
  assign dbz       = (divisor_reg == '0);
  assign ovf       = is_signed && (dividend_reg == MIN_VAL) && (&divisor_reg);

`ifdef DIV_EARLY_OUT_EN
  // Leading-zero count of |dividend|, capped so at least one iteration runs.
  logic [CNT_W-1:0] lz;
  always_comb begin
    lz = CNT_W'(XLEN - 1);
    for (int i = 0; i < XLEN; i++) begin
      if (abs_dvd[i]) lz = CNT_W'(XLEN - 1 - i);
    end
  end
  assign q_init   = abs_dvd << lz;
  assign cnt_init = CNT_W'(XLEN) - lz;
`else
  assign q_init   = abs_dvd;
  assign cnt_init = CNT_W'(XLEN);
`endif

  // Remainder stays below |divisor|, so the shifted value fits in XLEN+1 bits.
  assign shifted = {rem_reg[XLEN-1:0], q_reg[XLEN-1]};
  assign trial   = shifted - {1'b0, dvs_reg};
  assign ge      = (shifted >= {1'b0, dvs_reg});

  assign q_fix = neg_q_reg ? (~q_reg + 1'b1) : q_reg;
  assign r_fix = neg_r_reg ? (~rem_reg[XLEN-1:0] + 1'b1) : rem_reg[XLEN-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      op_reg       <= '0;
      tag_reg      <= '0;
      dividend_reg <= '0;
      divisor_reg  <= '0;
      dvs_reg      <= '0;
      rem_reg      <= '0;
      q_reg        <= '0;
      cnt_reg      <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      dbz_reg      <= 1'b0;
      ovf_reg      <= 1'b0;
      out_valid    <= 1'b0;
      result       <= '0;
      out_tag      <= '0;
    end else if (flush) begin
      state_reg <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            op_reg       <= op;
            tag_reg      <= tag;
            dividend_reg <= dividend;
            divisor_reg  <= divisor;
            state_reg    <= PREP;
          end
        end
        PREP: begin
          dbz_reg   <= dbz;
          ovf_reg   <= ovf;
          neg_q_reg <= dvd_neg ^ dvs_neg;
          neg_r_reg <= dvd_neg;
          dvs_reg   <= abs_dvs;
          rem_reg   <= '0;
          q_reg     <= q_init;
          cnt_reg   <= cnt_init;
          state_reg <= (dbz || ovf) ? FIX : CALC;
        end
        CALC: begin
          rem_reg <= ge ? trial : shifted;
          q_reg   <= {q_reg[XLEN-2:0], ge};
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == CNT_W'(1)) state_reg <= FIX;
        end
        FIX: begin
          if (dbz_reg)      result <= op_reg[1] ? dividend_reg : '1;
          else if (ovf_reg) result <= op_reg[1] ? '0 : MIN_VAL;
          else              result <= op_reg[1] ? r_fix : q_fix;
          out_tag   <= tag_reg;
          out_valid <= 1'b1;
          state_reg <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
